vme_cycle_bridge: RTL and testbench

Upstream front-end for the generated register banks. Converts a level-based, held bus request (address, data, direction, held until acknowledged) into the single-cycle `VMERdMem`/`VMEWrMem` strobes the register banks expect. It waits for the matching `VMERdDone`/`VMEWrDone`, then returns a four-phase acknowledge to the bus side. A missing done is bounded by a cycle timeout that completes the bus cycle with an error.

---
 rtl/vme_cycle_bridge.sv | 137 +++++++++++++
 tb/tb_vme_cycle_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_cycle_bridge.sv
// vme_cycle_bridge: turns a held, level-based bus request into the single-cycle
// VMERdMem/VMEWrMem strobes of the register banks, waits for the matching done
// and returns a four-phase acknowledge. A missing done ends the bus cycle with
// BusErr after TIMEOUT+1 cycles.
//
// Build option: define VME_CYCLE_BRIDGE_SYNC_EN to pass BusReq through a
// two-flop synchroniser when the bus side runs from another clock domain.
// Every bus-side latency then grows by two cycles.

module vme_cycle_bridge #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15   // legal range 1..255
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              BusReq,
  input  logic              BusWrite,
  input  logic [ADDR_W-1:0] BusAddr,
  input  logic [31:0]       BusWrData,
  output logic [31:0]       BusRdData,
  output logic              BusAck,
  output logic              BusErr,
  output logic [ADDR_W-1:0] VMEAddr,
  output logic [31:0]       VMEWrData,
  output logic              VMERdMem,
  output logic              VMEWrMem,
  input  logic [31:0]       VMERdData,
  input  logic              VMERdDone,
  input  logic              VMEWrDone
);

  localparam int                CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;      // latched direction of the current cycle
  logic             req;       // request as seen by the state machine
  logic             done_hit;  // done that matches the latched direction

`ifdef VME_CYCLE_BRIDGE_SYNC_EN
  logic req_meta;
  logic req_sync;

  // Two-flop synchroniser for a request launched from a foreign clock domain.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
    end else begin
      req_meta <= BusReq;
      req_sync <= req_meta;
    end
  end

  assign req = req_sync;
`else
  assign req = BusReq;
`endif

  // The opposite-direction done is never accepted, so a bank answering the
  // wrong strobe cannot complete the cycle.
  assign done_hit = wr_q ? VMEWrDone : VMERdDone;

  // Bus-cycle state machine; every output is a register.
  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from the values sampled at this edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      // NOTE: data registers are reset too, because a reset must leave every
      // output at zero, not just the control flags.
      state     <= S_IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      BusRdData <= '0;
      BusAck    <= 1'b0;
      BusErr    <= 1'b0;
      VMEAddr   <= '0;
      VMEWrData <= '0;
      VMERdMem  <= 1'b0;
      VMEWrMem  <= 1'b0;
    end else begin
      // Strobes are single-cycle: they fall on the edge after they rise.
      VMERdMem <= 1'b0;
      VMEWrMem <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            VMEAddr   <= BusAddr;
            VMEWrData <= BusWrData;
            wr_q      <= BusWrite;
            VMEWrMem  <= BusWrite;
            VMERdMem  <= !BusWrite;
            cnt       <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done_hit) begin
            BusRdData <= wr_q ? 32'h0 : VMERdData;
            BusErr    <= 1'b0;
            BusAck    <= 1'b1;
            state     <= S_ACK;
          end else if (cnt == CNT_TO) begin
            BusRdData <= 32'hFFFF_FFFF;
            BusErr    <= 1'b1;
            BusAck    <= 1'b1;
            state     <= S_ACK;
          end else begin
            // Leaving WAIT at CNT_TO keeps the counter from ever wrapping.
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ACK: begin
          if (!req) begin
            BusAck <= 1'b0;
            BusErr <= 1'b0;
            state  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // One dead cycle guarantees a gap between bus transactions.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vme_cycle_bridge.sv
// Self-checking bench for vme_cycle_bridge. Timing expectations are computed
// from the bus-cycle rules: a request is taken at the first edge that is both
// after it was raised and at least two edges after the previous release, the
// strobe follows that edge, and the acknowledge follows the matching done
// (or TIMEOUT+1 cycles after the strobe when no matching done arrives).
// Cycle c below means the interval after clock edge number c.

module tb_vme_cycle_bridge;

  localparam int ADDR_W = 8;
  localparam int TO     = 15;
`ifdef VME_CYCLE_BRIDGE_SYNC_EN
  localparam int SYNC   = 2;
`else
  localparam int SYNC   = 0;
`endif

  logic              Clk = 1'b0;
  logic              Rst;
  logic              BusReq;
  logic              BusWrite;
  logic [ADDR_W-1:0] BusAddr;
  logic [31:0]       BusWrData;
  logic [31:0]       BusRdData;
  logic              BusAck;
  logic              BusErr;
  logic [ADDR_W-1:0] VMEAddr;
  logic [31:0]       VMEWrData;
  logic              VMERdMem;
  logic              VMEWrMem;
  logic [31:0]       VMERdData;
  logic              VMERdDone;
  logic              VMEWrDone;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int earliest_edge = 0;

  vme_cycle_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .BusReq    (BusReq),
    .BusWrite  (BusWrite),
    .BusAddr   (BusAddr),
    .BusWrData (BusWrData),
    .BusRdData (BusRdData),
    .BusAck    (BusAck),
    .BusErr    (BusErr),
    .VMEAddr   (VMEAddr),
    .VMEWrData (VMEWrData),
    .VMERdMem  (VMERdMem),
    .VMEWrMem  (VMEWrMem),
    .VMERdData (VMERdData),
    .VMERdDone (VMERdDone),
    .VMEWrDone (VMEWrDone)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge Clk) begin
    if (VMERdMem === 1'b1) rd_pulses++;
    if (VMEWrMem === 1'b1) wr_pulses++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; done inputs are one-cycle pulses.
  task automatic tick();
    @(posedge Clk);
    #1;
    VMERdDone = 1'b0;
    VMEWrDone = 1'b0;
  endtask

  // Idle bus with junk on the inputs and stray done pulses that must be ignored.
  task automatic idle(input int n);
    int rd0, wr0;
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    for (int i = 0; i < n; i++) begin
      BusWrite  = 1'($urandom_range(0, 1));
      BusAddr   = ADDR_W'($urandom);
      BusWrData = $urandom;
      VMERdDone = 1'($urandom_range(0, 1));
      VMEWrDone = 1'($urandom_range(0, 1));
      tick();
      check("idle_ack", BusAck, 0);
      check("idle_err", BusErr, 0);
    end
    check("idle_no_strobe", (rd_pulses - rd0) + (wr_pulses - wr0), 0);
  endtask

  // One full bus cycle. lat: cycles from strobe to done (lat > TO means no done
  // inside the window); wrong: the bank answers with the other done.
  task automatic txn(input bit wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                     input logic [31:0] bank_rd, input int lat, input bit wrong,
                     input int hold);
    int raise_edge, exp_strobe, exp_ack, strobe_cyc, ack_cyc, done_cyc, k, rd0, wr0;
    bit timed_out;
    logic [31:0] exp_rd;
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    BusReq    = 1'b1;
    BusWrite  = wr;
    BusAddr   = addr;
    BusWrData = wd;
    VMERdData = bank_rd;
    raise_edge = cyc + 1;
    exp_strobe = ((raise_edge > earliest_edge) ? raise_edge : earliest_edge) + SYNC;
    timed_out  = wrong || (lat > TO);
    exp_ack    = exp_strobe + 1 + (timed_out ? TO : lat);
    exp_rd     = timed_out ? 32'hFFFF_FFFF : (wr ? 32'h0 : bank_rd);
    strobe_cyc = -1;
    ack_cyc    = -1;
    done_cyc   = -1;
    for (int i = 0; i < TO + 40 && ack_cyc < 0; i++) begin
      tick();
      if (BusAck === 1'b1) begin
        ack_cyc = cyc;
      end else begin
        if (strobe_cyc < 0 && (VMERdMem === 1'b1 || VMEWrMem === 1'b1)) begin
          strobe_cyc = cyc;
          check("vme_addr", VMEAddr, addr);
          check("vme_wr_data", VMEWrData, wd);
          done_cyc = cyc + lat;
        end
        if (cyc == done_cyc) begin
          if (wr ^ wrong) VMEWrDone = 1'b1;
          else            VMERdDone = 1'b1;
        end
      end
    end
    check("strobe_cycle", strobe_cyc, exp_strobe);
    check("ack_cycle", ack_cyc, exp_ack);
    check("ack_err", BusErr, timed_out);
    check("ack_rd_data", BusRdData, exp_rd);
    for (int h = 0; h < hold; h++) begin
      if (h == 0 && timed_out) VMERdDone = 1'b1;   // late done after the timeout
      if (h == 1) VMEWrDone = 1'b1;                // stray done while acknowledged
      tick();
      check("hold_ack", BusAck, 1);
      check("hold_err", BusErr, timed_out);
      check("hold_rd_data", BusRdData, exp_rd);
    end
    BusReq = 1'b0;
    k = cyc + 1;
    while (cyc < k + SYNC - 1) begin
      tick();
      check("ack_until_drop", BusAck, 1);
    end
    tick();
    check("ack_released", BusAck, 0);
    check("err_released", BusErr, 0);
    check("rd_strobes", rd_pulses - rd0, wr ? 0 : 1);
    check("wr_strobes", wr_pulses - wr0, wr ? 1 : 0);
    earliest_edge = k + 2;
  endtask

  initial begin
    int rd0, wr0;
    Rst       = 1'b1;
    BusReq    = 1'b0;
    BusWrite  = 1'b0;
    BusAddr   = '0;
    BusWrData = '0;
    VMERdData = '0;
    VMERdDone = 1'b0;
    VMEWrDone = 1'b0;
    tick();
    tick();
    check("rst_ack", BusAck, 0);
    check("rst_err", BusErr, 0);
    check("rst_rd_data", BusRdData, 0);
    check("rst_vme_addr", VMEAddr, 0);
    check("rst_vme_wr_data", VMEWrData, 0);
    check("rst_rd_mem", VMERdMem, 0);
    check("rst_wr_mem", VMEWrMem, 0);
    Rst = 1'b0;
    earliest_edge = cyc + 1;
    idle(2);

    // Write with a two-cycle bank, read with a one-cycle bank.
    txn(1'b1, 8'h04, 32'h0000_00A5, $urandom, 2, 1'b0, 2);
    idle(2);
    txn(1'b0, 8'h10, $urandom, 32'h0000_005A, 1, 1'b0, 3);
    idle(1);
    // Timeout with a late read done, then the wrong done during a read.
    txn(1'b0, 8'h20, $urandom, $urandom, TO + 10, 1'b0, 3);
    idle(1);
    txn(1'b0, 8'h21, $urandom, $urandom, 3, 1'b1, 1);
    idle(1);
    // Zero-latency read and a done in the last cycle before the timeout.
    txn(1'b0, 8'h22, $urandom, $urandom, 0, 1'b0, 1);
    txn(1'b1, 8'h23, $urandom, $urandom, TO, 1'b0, 0);
    // Back-to-back: request re-raised right after the release.
    txn(1'b1, 8'h30, $urandom, $urandom, 1, 1'b0, 0);
    txn(1'b0, 8'h31, $urandom, $urandom, 0, 1'b0, 0);
    idle(2);

    // Reset while waiting for a done: outputs clear and nothing is reissued.
    BusReq    = 1'b1;
    BusWrite  = 1'b0;
    BusAddr   = 8'h5C;
    BusWrData = $urandom;
    VMERdData = $urandom;
    for (int i = 0; i < 10 && VMERdMem !== 1'b1; i++) tick();
    check("pre_rst_strobe", VMERdMem, 1);
    tick();
    tick();
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    Rst    = 1'b1;
    BusReq = 1'b0;
    tick();
    check("mid_rst_ack", BusAck, 0);
    check("mid_rst_err", BusErr, 0);
    check("mid_rst_rd_data", BusRdData, 0);
    check("mid_rst_vme_addr", VMEAddr, 0);
    check("mid_rst_vme_wr_data", VMEWrData, 0);
    check("mid_rst_rd_mem", VMERdMem, 0);
    check("mid_rst_wr_mem", VMEWrMem, 0);
    Rst = 1'b0;
    earliest_edge = cyc + 1;
    idle(6);
    check("rst_no_reissue", (rd_pulses - rd0) + (wr_pulses - wr0), 0);

    // Randomised traffic, including latencies past the timeout and wrong dones.
    for (int t = 0; t < 24; t++) begin
      txn(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, $urandom,
          $urandom_range(0, TO + 4), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
      idle($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
